// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU instruction sequencer: opcodes, instruction
// field positions and the controller state encoding.
package fpu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int FIELD_W  = 6;
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 30;
  localparam int HALT_BIT = 29;
  localparam int DST_HI   = 17;
  localparam int DST_LO   = 12;
  localparam int SRCA_HI  = 11;
  localparam int SRCA_LO  = 6;
  localparam int SRCB_HI  = 5;
  localparam int SRCB_LO  = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_RDA,
    ST_RDB,
    ST_LATB,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/fpu_instr_decode.sv
// Combinational split of a latched instruction word into its fields.
module fpu_instr_decode
  import fpu_seq_pkg::*;
(
  input  logic [31:0]        ir,
  output logic [1:0]         op,
  output logic               halt,
  output logic [FIELD_W-1:0] dst,
  output logic [FIELD_W-1:0] srca,
  output logic [FIELD_W-1:0] srcb
);

  assign op   = ir[OP_HI:OP_LO];
  assign halt = ir[HALT_BIT];
  assign dst  = ir[DST_HI:DST_LO];
  assign srca = ir[SRCA_HI:SRCA_LO];
  assign srcb = ir[SRCB_HI:SRCB_LO];

  // Bits 28..18 carry no meaning and are dropped.
  logic unused_bits;
  assign unused_bits = ^ir[28:18];

endmodule

// File: rtl/fpu_sequencer.sv
// Instruction-driven controller feeding the `operation` FPU from data memory.
// Optional retired-instruction counter enabled by defining FPU_SEQ_INSTR_CNT_EN.
module fpu_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int IADDR_W  = 8,
  parameter int DADDR_W  = 6,
  parameter int EXEC_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DADDR_W-1:0] dmem_addr,
  input  logic [63:0]        dmem_rdata,
  output logic               dmem_we,
  output logic [63:0]        dmem_wdata,
  output logic               fpu_enable,
  output logic [63:0]        fpu_a,
  output logic [63:0]        fpu_b,
  output logic [1:0]         fpu_op,
  input  logic [63:0]        fpu_c,
  output logic [31:0]        instr_count
);

  localparam int LAT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

  state_t              state_reg, state_next;
  logic [IADDR_W-1:0]  pc_reg;
  logic [31:0]         ir_reg;
  logic [63:0]         a_reg, b_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic                lat_last;

  logic [1:0]          dec_op;
  logic                dec_halt;
  logic [FIELD_W-1:0]  dec_dst, dec_srca, dec_srcb;

  fpu_instr_decode u_decode (
    .ir   (ir_reg),
    .op   (dec_op),
    .halt (dec_halt),
    .dst  (dec_dst),
    .srca (dec_srca),
    .srcb (dec_srcb)
  );

  assign lat_last   = (lat_cnt_reg == LAT_W'(EXEC_LAT - 1));
  assign imem_addr  = pc_reg;
  assign fpu_a      = a_reg;
  assign fpu_b      = b_reg;
  assign fpu_op     = dec_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    dmem_addr  = '0;
    dmem_we    = 1'b0;
    dmem_wdata = '0;
    fpu_enable = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH:  state_next = ST_DECODE;
      // Halt is decided from the fresh memory word, in parallel with latching ir.
      ST_DECODE: state_next = imem_rdata[HALT_BIT] ? ST_HALT : ST_RDA;
      ST_RDA: begin
        dmem_addr  = dec_srca[DADDR_W-1:0];
        state_next = ST_RDB;
      end
      ST_RDB: begin
        dmem_addr  = dec_srcb[DADDR_W-1:0];
        state_next = ST_LATB;
      end
      ST_LATB:   state_next = ST_EXEC;
      ST_EXEC: begin
        fpu_enable = 1'b1;
        if (lat_last) state_next = ST_WB;
      end
      ST_WB: begin
        fpu_enable = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = dec_dst[DADDR_W-1:0];
        dmem_wdata = fpu_c;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_next = ST_FETCH;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= '0;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      lat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_HALT: if (start) pc_reg <= '0;
        ST_DECODE:        ir_reg <= imem_rdata;
        ST_RDB:           a_reg  <= dmem_rdata;
        ST_LATB:          b_reg  <= dmem_rdata;
        ST_EXEC:          lat_cnt_reg <= lat_last ? '0 : lat_cnt_reg + 1'b1;
        ST_WB:            pc_reg <= pc_reg + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FPU_SEQ_INSTR_CNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if ((state_reg == ST_IDLE || state_reg == ST_HALT) && start) begin
      count_reg <= '0;
    end else if (state_reg == ST_WB && count_reg != 32'hFFFF_FFFF) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign instr_count = count_reg;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer with behavioural memories and a real-valued FPU model.
module tb_fpu_sequencer;

  localparam int IW = 2;
  localparam int DW = 6;
  localparam logic [31:0] HLT = 32'h2000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [IW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [DW-1:0] dmem_addr;
  logic [63:0]   dmem_rdata;
  logic          dmem_we;
  logic [63:0]   dmem_wdata;
  logic          fpu_enable;
  logic [63:0]   fpu_a, fpu_b, fpu_c;
  logic [1:0]    fpu_op;
  logic [31:0]   instr_count;

  logic [31:0]   imem [0:3];
  logic [63:0]   dmem [0:63];
  logic          tb_iwe = 1'b0, tb_dwe = 1'b0, log_clr = 1'b0;
  logic [1:0]    tb_iaddr = '0;
  logic [5:0]    tb_daddr = '0;
  logic [31:0]   tb_idata = '0;
  logic [63:0]   tb_ddata = '0;

  int cyc = 0, wr_n = 0, first_we = 0, last_we = 0, start_cyc = 0;
  logic gap_bad = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fpu_sequencer #(.IADDR_W(IW), .DADDR_W(DW), .EXEC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .fpu_enable(fpu_enable), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_c(fpu_c),
    .instr_count(instr_count)
  );

  function automatic logic [63:0] fpu_model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    real ra, rb, r;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    case (op)
      2'b00:   r = ra + rb;
      2'b01:   r = ra - rb;
      2'b10:   r = ra * rb;
      default: r = ra / rb;
    endcase
    return $realtobits(r);
  endfunction

  assign fpu_c = fpu_enable ? fpu_model(fpu_op, fpu_a, fpu_b) : 64'h0;

  always @(posedge clk) begin
    if (tb_iwe) imem[tb_iaddr] <= tb_idata;
    imem_rdata <= imem[imem_addr];
  end

  always @(posedge clk) begin
    dmem_rdata <= dmem[dmem_addr];
    if (tb_dwe)       dmem[tb_daddr] <= tb_ddata;
    else if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  // Write log: count, first write cycle, and whether any two writes were not 8 cycles apart.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (log_clr) begin
      wr_n    <= 0;
      gap_bad <= 1'b0;
    end else if (dmem_we) begin
      wr_n <= wr_n + 1;
      if (wr_n == 0)               first_we <= cyc;
      else if (cyc - last_we != 8) gap_bad  <= 1'b1;
      last_we <= cyc;
    end
  end

  typedef struct {
    logic [3:0][31:0] prog;
    bit               pre;
    int               xs;
    int               pa;
    int               wr;
    int               pc;
    int               dl;
    logic [5:0]       a0;
    logic [63:0]      d0;
    logic [5:0]       a1;
    logic [63:0]      d1;
  } vec_t;

  vec_t vt [7];

  function automatic vec_t mk(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                              input logic [31:0] p3, input bit pre, input int xs, input int pa,
                              input int wr, input int pc, input int dl, input logic [5:0] a0,
                              input logic [63:0] d0, input logic [5:0] a1, input logic [63:0] d1);
    vec_t v;
    v.prog = {p3, p2, p1, p0};
    v.pre = pre; v.xs = xs; v.pa = pa; v.wr = wr; v.pc = pc; v.dl = dl;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic ipoke(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_iwe = 1'b1; tb_iaddr = a; tb_idata = d;
    @(negedge clk);
    tb_iwe = 1'b0;
  endtask

  task automatic dpoke(input logic [5:0] a, input logic [63:0] d);
    @(negedge clk);
    tb_dwe = 1'b1; tb_daddr = a; tb_ddata = d;
    @(negedge clk);
    tb_dwe = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 4; i++) ipoke(2'(i), v.prog[i]);
    if (v.pre) begin
      dpoke(6'd0, 64'h4000_0000_0000_0000);
      dpoke(6'd1, 64'hBFE0_0000_0000_0000);
      for (int a = 2; a < 6; a++) dpoke(6'(a), 64'h0);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; log_clr = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; log_clr = 1'b0;
    start_cyc = cyc;
  endtask

  // Runs until done (bounded); optionally pulses start while busy and patches imem[0] to a halt.
  task automatic run(input int xs, input int pa, output int lat);
    int kk;
    lat = -1;
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      kk = cyc - start_cyc;
      start    = (xs != 0 && kk == xs);
      tb_iwe   = (pa != 0 && kk == pa);
      tb_iaddr = 2'd0;
      tb_idata = HLT;
      if (done) begin
        lat = kk;
        break;
      end
    end
    start  = 1'b0;
    tb_iwe = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},   64'(busy),        64'd0);
    chk({tag, "_done"},   64'(done),        64'd0);
    chk({tag, "_we"},     64'(dmem_we),     64'd0);
    chk({tag, "_en"},     64'(fpu_enable),  64'd0);
    chk({tag, "_daddr"},  64'(dmem_addr),   64'd0);
    chk({tag, "_wdata"},  dmem_wdata,       64'd0);
    chk({tag, "_iaddr"},  64'(imem_addr),   64'd0);
    chk({tag, "_fpua"},   fpu_a,            64'd0);
    chk({tag, "_fpub"},   fpu_b,            64'd0);
    chk({tag, "_op"},     64'(fpu_op),      64'd0);
    chk({tag, "_cnt"},    64'(instr_count), 64'd0);
  endtask

  initial begin
    int lat, ec, off;

    vt[0] = mk(32'h0000_2001, HLT, HLT, HLT, 1'b1, 0, 0, 1, 1, 10,
               6'd2, 64'h3FF8_0000_0000_0000, 6'd2, 64'h3FF8_0000_0000_0000);
    vt[1] = mk(32'h4000_3001, 32'h8000_4001, HLT, HLT, 1'b1, 3, 0, 2, 2, 18,
               6'd3, 64'h4004_0000_0000_0000, 6'd4, 64'hBFF0_0000_0000_0000);
    vt[2] = mk(32'hC000_5001, HLT, HLT, HLT, 1'b1, 0, 0, 1, 1, 10,
               6'd5, 64'hC010_0000_0000_0000, 6'd5, 64'hC010_0000_0000_0000);
    vt[3] = mk(HLT, 32'h0000_2001, HLT, HLT, 1'b1, 0, 0, 0, 0, 2,
               6'd0, 64'h4000_0000_0000_0000, 6'd2, 64'h0);
    vt[4] = mk(32'h0000_0001, HLT, HLT, HLT, 1'b1, 0, 0, 1, 1, 10,
               6'd0, 64'h3FF8_0000_0000_0000, 6'd1, 64'hBFE0_0000_0000_0000);
    vt[5] = mk(32'h0000_0001, HLT, HLT, HLT, 1'b0, 0, 0, 1, 1, 10,
               6'd0, 64'h3FF0_0000_0000_0000, 6'd1, 64'hBFE0_0000_0000_0000);
    vt[6] = mk(32'h0000_2001, 32'h4000_3001, 32'h8000_4001, 32'hC000_5001, 1'b1, 20, 3, 4, 0, 34,
               6'd2, 64'h3FF8_0000_0000_0000, 6'd5, 64'hC010_0000_0000_0000);

    repeat (3) @(negedge clk);
    chk_quiet("reset");
    $display("reset: busy=%0d done=%0d iaddr=%0d", busy, done, imem_addr);
    rst_n = 1'b1;

    // Reset asserted in EXEC and in WB must drop everything without a write.
    for (int r = 0; r < 2; r++) begin
      off = (r == 0) ? 5 : 7;
      load(vt[0]);
      pulse_start();
      while (cyc - start_cyc < off) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_quiet($sformatf("midrst%0d", off));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk($sformatf("midrst%0d_wr", off),   64'(wr_n), 64'd0);
      chk($sformatf("midrst%0d_dmem", off), dmem[2],   64'd0);
      $display("midrst at +%0d: writes=%0d dmem[2]=%h", off, wr_n, dmem[2]);
    end

    for (int i = 0; i < 7; i++) begin
      load(vt[i]);
      run(vt[i].xs, vt[i].pa, lat);
`ifdef FPU_SEQ_INSTR_CNT_EN
      ec = vt[i].wr;
`else
      ec = 0;
`endif
      chk($sformatf("v%0d_done", i),  64'(done),        64'd1);
      chk($sformatf("v%0d_lat", i),   64'(lat),         64'(vt[i].dl));
      chk($sformatf("v%0d_pc", i),    64'(imem_addr),   64'(vt[i].pc));
      chk($sformatf("v%0d_wr", i),    64'(wr_n),        64'(vt[i].wr));
      chk($sformatf("v%0d_cnt", i),   64'(instr_count), 64'(ec));
      chk($sformatf("v%0d_m%0d", i, vt[i].a0), dmem[vt[i].a0], vt[i].d0);
      chk($sformatf("v%0d_m%0d", i, vt[i].a1), dmem[vt[i].a1], vt[i].d1);
      if (vt[i].wr != 0) begin
        chk($sformatf("v%0d_first_we", i), 64'(first_we - start_cyc), 64'd7);
        chk($sformatf("v%0d_gap", i),      64'(gap_bad),              64'd0);
      end
      $display("vec %0d: lat=%0d pc=%0d writes=%0d count=%0d m[%0d]=%h m[%0d]=%h",
               i, lat, imem_addr, wr_n, instr_count, vt[i].a0, dmem[vt[i].a0], vt[i].a1, dmem[vt[i].a1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
